// File: rtl/rs232_rx_frame_ctrl_if.sv
// rs232_rx_frame_ctrl_if: byte-receiver handshake and replay stream of the frame controller.
// master is the controller's view; slave is the receiver/downstream view.
interface rs232_rx_frame_ctrl_if;
    logic [7:0] rx_data;
    logic       flag_rxne;
    logic       read_done;
    logic [7:0] out_addr;
    logic [7:0] out_len;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;
    modport master (
        input  rx_data, flag_rxne, out_ready,
        output read_done, out_addr, out_len, out_data, out_valid, out_last,
               frame_done, frame_err, err_code, busy
    );
    modport slave (
        output rx_data, flag_rxne, out_ready,
        input  read_done, out_addr, out_len, out_data, out_valid, out_last,
               frame_done, frame_err, err_code, busy
    );
endinterface

// File: rtl/rs232_rx_frame_ctrl.sv
// rs232_rx_frame_ctrl: drains rs232_rx bytes, parses header/addr/len/payload/checksum frames
// and replays checksum-clean payloads on a valid/ready stream.
module rs232_rx_frame_ctrl #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter int         TIMEOUT_CLKS = 57288
) (
    input logic                   sys_clk,
    input logic                   sys_rst_n,
    rs232_rx_frame_ctrl_if.master bus
);
    localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0] ML = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS - 1);
    typedef enum logic [2:0] {HUNT, GET_ADDR, GET_LEN, GET_DATA, GET_CSUM, REPLAY} state_t;
    state_t st, nxt;
    logic ack_wait, accept, in_rx, tmo, bad_len, last_idx, fire, len_err, csum_err;
    logic [7:0] idx, csum;
    logic [TW-1:0] tcnt;
    logic [7:0] mem [MAX_LEN];
    assign accept   = bus.flag_rxne && !ack_wait && st != REPLAY;
    assign in_rx    = st inside {GET_ADDR, GET_LEN, GET_DATA, GET_CSUM};
    assign tmo      = in_rx && !accept && tcnt == TMAX;
    assign bad_len  = bus.rx_data == 8'd0 || bus.rx_data > ML;
    assign last_idx = idx == bus.out_len - 8'd1;
    assign fire     = st == REPLAY && bus.out_ready;
    assign len_err  = accept && st == GET_LEN && bad_len;
    assign csum_err = accept && st == GET_CSUM && bus.rx_data != csum;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) st <= HUNT;
        else st <= nxt;
    end
    // An accepted byte always beats a timeout expiring on the same edge.
    always_comb begin
        nxt = st;
        case (st)
            HUNT:     nxt = accept && bus.rx_data == HEADER ? GET_ADDR : HUNT;
            GET_ADDR: nxt = accept ? GET_LEN : tmo ? HUNT : st;
            GET_LEN:  nxt = accept ? (bad_len ? HUNT : GET_DATA) : tmo ? HUNT : st;
            GET_DATA: nxt = accept && last_idx ? GET_CSUM : tmo ? HUNT : st;
            GET_CSUM: nxt = accept ? (csum_err ? HUNT : REPLAY) : tmo ? HUNT : st;
            REPLAY:   nxt = fire && last_idx ? HUNT : st;
            default:  nxt = HUNT;
        endcase
    end
    always_comb begin
        bus.busy      = st != HUNT;
        bus.out_valid = st == REPLAY;
        bus.out_last  = st == REPLAY && last_idx;
        bus.out_data  = st == REPLAY ? mem[idx[AW-1:0]] : 8'd0;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.read_done  <= 1'b1;
            bus.out_addr   <= 8'd0;
            bus.out_len    <= 8'd0;
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.err_code   <= 2'd0;
            ack_wait       <= 1'b0;
            tcnt           <= '0;
            idx            <= 8'd0;
            csum           <= 8'd0;
        end else begin
            bus.read_done  <= !accept;
            ack_wait       <= accept || (ack_wait && bus.flag_rxne);
            tcnt           <= in_rx && !accept ? tcnt + TW'(1) : '0;
            bus.frame_done <= fire && last_idx;
            bus.frame_err  <= len_err || csum_err || tmo;
            if (len_err || csum_err || tmo) bus.err_code <= tmo ? 2'd3 : len_err ? 2'd2 : 2'd1;
            if (accept) csum <= st == HUNT ? 8'd0 : csum + bus.rx_data;
            if (accept && st == GET_ADDR) bus.out_addr <= bus.rx_data;
            if (accept && st == GET_LEN && !bad_len) bus.out_len <= bus.rx_data;
            if (accept && (st == GET_LEN || st == GET_CSUM)) idx <= 8'd0;
            else if ((accept && st == GET_DATA) || fire) idx <= idx + 8'd1;
        end
    end
    // Payload storage needs no reset; it is only read after being written in GET_DATA.
    always_ff @(posedge sys_clk) begin
        if (accept && st == GET_DATA) mem[idx[AW-1:0]] <= bus.rx_data;
    end
endmodule

// File: doc/rs232_rx_frame_ctrl.md
Name: rs232_rx_frame_ctrl

Overview:
Sequences the rs232_rx byte receiver. It drains bytes through the flag_rxne / read_done handshake and parses framed commands of the form header, address, length, payload, checksum. Each payload is buffered, and only frames with a correct checksum are replayed on a valid/ready stream to downstream command logic. Framing errors, checksum errors and inter-byte timeouts are reported with an error pulse and code.

Parameters:
MAX_LEN, 16, payload buffer depth in bytes; legal length field is 1..MAX_LEN.
HEADER, 8'hA5, frame start byte.
TIMEOUT_CLKS, 57288, maximum idle sys_clk cycles between bytes inside a frame (11 bit times at 5208 clk/bit).

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous active-low reset
rx_data  in  8  byte from rs232_rx, valid while flag_rxne=1
flag_rxne  in  1  receiver holds an unread byte
read_done  out  1  active-low acknowledge to rs232_rx; idle 1
out_addr  out  8  address field of the frame being replayed
out_len  out  8  length field of the frame being replayed
out_data  out  8  payload byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts a beat
out_last  out  1  current beat is the final payload byte
frame_done  out  1  one-cycle pulse after the final beat is accepted
frame_err  out  1  one-cycle pulse on frame abort
err_code  out  2  1=checksum, 2=bad length, 3=timeout; held until next frame_err
busy  out  1  high whenever state is not HUNT

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous and active-low (sys_rst_n).
- Reset values: read_done=1, every other output 0, state=HUNT, buffer index 0, ack_wait=0, timeout counter 0.
- Reset mid-frame: the partial frame is discarded and no error is reported.
- Byte acceptance (all receive states):
  - A byte is accepted on the edge where flag_rxne=1, ack_wait=0 and the state is not REPLAY.
  - On that edge rx_data is latched, read_done is driven 0 for exactly one cycle, and ack_wait is set.
  - ack_wait clears on the first edge where flag_rxne=0.
  - No further byte is accepted while ack_wait=1.
- States:
  - HUNT: an accepted byte equal to HEADER moves to GET_ADDR and clears the checksum. Any other byte is acknowledged and dropped.
  - GET_ADDR: store the byte in out_addr, add it to the checksum, go to GET_LEN.
  - GET_LEN: add the byte to the checksum. A value of 0 or greater than MAX_LEN gives frame_err with err_code=2 and a return to HUNT. Otherwise store it in out_len, reset the index, go to GET_DATA.
  - GET_DATA: write buffer[idx], add the byte to the checksum, increment idx. When idx reaches out_len-1, go to GET_CSUM.
  - GET_CSUM: the checksum is the 8-bit sum, mod 256, of addr, len and all payload bytes. If the received byte equals it, go to REPLAY with idx=0. Otherwise frame_err with err_code=1 and a return to HUNT.
  - REPLAY:
    - out_data=buffer[idx] and out_valid=1.
    - A beat transfers when out_valid and out_ready are both 1; idx then increments.
    - out_last=1 when idx=out_len-1.
    - After the last beat: out_valid=0 and frame_done pulses on the next cycle, with a return to HUNT in the same cycle.
    - out_valid stays high regardless of out_ready.
    - out_addr and out_len stay stable for the whole of REPLAY.
- Back-pressure: while in REPLAY, flag_rxne is never acknowledged. The byte waits in rs232_rx and is accepted on the first cycle back in HUNT.
- Timeout:
  - The counter runs only in GET_ADDR, GET_DATA, GET_LEN and GET_CSUM, and resets on every accepted byte.
  - When it reaches TIMEOUT_CLKS-1: frame_err with err_code=3 and a return to HUNT.
  - If a byte is accepted in the same cycle, the acceptance wins and no timeout is reported.
- Byte after an error: a byte arriving in the cycle after an error is handled as a HUNT byte.

Test Plan:
- Good frame: send A5 10 02 11 22 45 with out_ready=1. Expect two beats, 11 then 22; out_last on 22; out_addr=10; out_len=02; frame_done pulses once; read_done goes low for one cycle six times.
- Bad checksum: send A5 10 02 11 22 46. Expect no out_valid, a frame_err pulse, err_code=1, and busy=0 afterwards.
- Bad length: send A5 10 00, then separately A5 10 11 (17 > MAX_LEN). Expect frame_err with err_code=2 after the length byte in both cases.
- Timeout: send A5 10, then hold rx idle for more than 57288 cycles. Expect frame_err with err_code=3. A following good frame is then accepted normally.
- Back-pressure: good frame with out_ready=0 for 100 cycles, and a new A5 byte arriving during REPLAY. Expect out_valid held with out_data=11 stable and read_done staying 1 until REPLAY ends; the A5 is then accepted.
- Hunt and reset: send garbage AA FA (both acknowledged and dropped, busy stays 0), then assert sys_rst_n low in the middle of GET_DATA. Expect all outputs at reset values immediately and no frame_err.
